bpsk_tx_framer: RTL and testbench

// - Frame scheduler in front of the BPSK modulator's bit input (idata/ivalid/iready).
// - On a start request, emits preamble, sync word, LEN payload bytes (serialised MSB first)
//   and a zero guard gap as one continuous bit stream.
// - Payload bytes come from an upstream byte source over a valid/ready handshake.
// - Runs in the modulator's clock domain (DA clock).

---
 rtl/bpsk_tx_framer_if.sv | 26 ++
 rtl/bpsk_tx_framer.sv | 236 +++++++++++++++++++++++
 tb/tb_bpsk_tx_framer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_tx_framer_if.sv
// Bus bundle for bpsk_tx_framer: frame control, payload byte stream and modulator bit stream.
// Handshakes are valid/ready: a byte moves on s_valid && s_ready, a bit moves on ovalid && mod_ready,
// and whoever holds valid high keeps its data stable until the matching ready is seen.
interface bpsk_tx_framer_if;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       odata;
  logic       ovalid;
  logic       mod_ready;
  logic [2:0] dbg_state;

  modport master (
    output start, len, s_data, s_valid, mod_ready,
    input  busy, done, s_ready, odata, ovalid, dbg_state
  );

  modport slave (
    input  start, len, s_data, s_valid, mod_ready,
    output busy, done, s_ready, odata, ovalid, dbg_state
  );
endinterface

// File: rtl/bpsk_tx_framer.sv
// Frame scheduler for the BPSK modulator: preamble, sync word, payload bytes (MSB first), guard gap.
// Optional CRC-8 trailer after the payload when BPSK_TX_CRC8_EN is defined.
module bpsk_tx_framer #(
  parameter int                PRE_LEN   = 32,
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'h1ACF,
  parameter int                GAP_LEN   = 8
) (
  input  logic            clk,
  input  logic            rst,
  bpsk_tx_framer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SYNC = 3'd2,
    S_PAY  = 3'd3,
`ifdef BPSK_TX_CRC8_EN
    S_CRC  = 3'd4,
`endif
    S_GAP  = 3'd5
  } state_t;

  localparam logic [31:0] SYNC_VEC  = 32'(SYNC_WORD);
  localparam logic [4:0]  SYNC_MSB  = 5'(SYNC_W - 1);
  localparam logic [4:0]  SYNC_PEN  = 5'(SYNC_W - 2);
  localparam logic [7:0]  PRE_LAST  = 8'(PRE_LEN - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_LEN - 1);

  state_t     state_q, state_d;
  logic       odata_q, odata_d;
  logic       ovalid_q, ovalid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] sync_q, sync_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] sh_q, sh_d;
`ifdef BPSK_TX_CRC8_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
`endif

  logic accept, need, s_ready_c, to_tail, to_gap, to_idle;

  assign accept = ovalid_q && bus.mod_ready;
  // odata_q is the bit on offer; bit_q counts payload/CRC bits still waiting behind it in sh_q.
  assign need   = (bit_q == 3'd0) && (!ovalid_q || accept);

  always_comb begin
    state_d   = state_q;
    odata_d   = odata_q;
    ovalid_d  = ovalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    sync_d    = sync_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sh_d      = sh_q;
`ifdef BPSK_TX_CRC8_EN
    crc_d     = crc_q;
`endif
    s_ready_c = 1'b0;
    to_tail   = 1'b0;
    to_gap    = 1'b0;
    to_idle   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !done_q) begin
          state_d  = S_PRE;
          byte_d   = bus.len;
          cnt_d    = 8'd0;
          sync_d   = 5'd0;
          bit_d    = 3'd0;
          sh_d     = 8'd0;
          odata_d  = 1'b1;
          ovalid_d = 1'b1;
          busy_d   = 1'b1;
`ifdef BPSK_TX_CRC8_EN
          crc_d    = 8'd0;
`endif
        end
      end
      S_PRE: begin
        if (accept) begin
          if (cnt_q == PRE_LAST) begin
            sync_d  = 5'd0;
            odata_d = SYNC_VEC[SYNC_MSB];
            state_d = (SYNC_W == 1 && byte_q != 8'd0) ? S_PAY : S_SYNC;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            odata_d = cnt_q[0];
          end
        end
      end
      S_SYNC: begin
        if (accept) begin
          if (sync_q == SYNC_MSB) begin
            to_tail = 1'b1;
          end else begin
            sync_d  = sync_q + 5'd1;
            odata_d = SYNC_VEC[SYNC_MSB - sync_q - 5'd1];
            // Hand over to PAY while the last sync bit is on offer so byte 0 follows with no bubble.
            if (sync_q == SYNC_PEN && byte_q != 8'd0) state_d = S_PAY;
          end
        end
      end
      S_PAY: begin
        s_ready_c = need && (byte_q != 8'd0);
        if (need) begin
          if (byte_q != 8'd0) begin
            if (bus.s_valid) begin
              odata_d  = bus.s_data[7];
              sh_d     = {bus.s_data[6:0], 1'b0};
              bit_d    = 3'd7;
              byte_d   = byte_q - 8'd1;
              ovalid_d = 1'b1;
`ifdef BPSK_TX_CRC8_EN
              crc_d    = crc8_byte(crc_q, bus.s_data);
`endif
            end else begin
              ovalid_d = 1'b0;
            end
          end else if (accept) begin
            to_tail = 1'b1;
          end
        end else if (accept) begin
          odata_d = sh_q[7];
          sh_d    = {sh_q[6:0], 1'b0};
          bit_d   = bit_q - 3'd1;
        end
      end
`ifdef BPSK_TX_CRC8_EN
      S_CRC: begin
        if (accept) begin
          if (bit_q == 3'd0) begin
            to_gap = 1'b1;
          end else begin
            odata_d = sh_q[7];
            sh_d    = {sh_q[6:0], 1'b0};
            bit_d   = bit_q - 3'd1;
          end
        end
      end
`endif
      S_GAP: begin
        if (accept) begin
          if (cnt_q == GAP_LAST) to_idle = 1'b1;
          else                   cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BPSK_TX_CRC8_EN
    if (to_tail) begin
      state_d  = S_CRC;
      odata_d  = crc_q[7];
      sh_d     = {crc_q[6:0], 1'b0};
      bit_d    = 3'd7;
      ovalid_d = 1'b1;
    end
`else
    if (to_tail) to_gap = 1'b1;
`endif

    if (to_gap) begin
      if (GAP_LEN == 0) begin
        to_idle = 1'b1;
      end else begin
        state_d  = S_GAP;
        cnt_d    = 8'd0;
        odata_d  = 1'b0;
        ovalid_d = 1'b1;
      end
    end

    if (to_idle) begin
      state_d  = S_IDLE;
      odata_d  = 1'b0;
      ovalid_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      odata_q  <= 1'b0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 8'd0;
      sync_q   <= 5'd0;
      bit_q    <= 3'd0;
      byte_q   <= 8'd0;
      sh_q     <= 8'd0;
`ifdef BPSK_TX_CRC8_EN
      crc_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
`ifdef BPSK_TX_CRC8_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign bus.odata     = odata_q;
  assign bus.ovalid    = ovalid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.s_ready   = s_ready_c;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Bench for bpsk_tx_framer: vector table of frames, bit scoreboard, hand-written corner sequences.
// Builds with or without BPSK_TX_CRC8_EN; a second instance covers GAP_LEN=0.
`timescale 1ns/1ps
module tb_bpsk_tx_framer;
  localparam int          PRE_LEN   = 32;
  localparam int          SYNC_W    = 16;
  localparam logic [15:0] SYNC_WORD = 16'h1ACF;
  localparam int          GAP_LEN   = 8;
`ifdef BPSK_TX_CRC8_EN
  localparam int          CRC_BITS  = 8;
`else
  localparam int          CRC_BITS  = 0;
`endif

  typedef struct {
    int         len;
    logic [7:0] seed;
    int         mr_mode;   // 0: always ready, 1: toggle, 2: random
    int         stall;     // cycles s_valid is held low right after byte 0 is taken
    int         mid_start;
    int         exp_bits;
  } vec_t;

  logic clk, rst;
  bpsk_tx_framer_if bus();
  bpsk_tx_framer_if bus2();

  bpsk_tx_framer dut    (.clk(clk), .rst(rst), .bus(bus));
  bpsk_tx_framer #(.GAP_LEN(0)) dut_g0 (.clk(clk), .rst(rst), .bus(bus2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard
  logic [0:0] exp_q[$];
  logic [0:0] exp2_q[$];
  logic [7:0] src[$];

  task automatic build_frame(input int n, input int gap);
    logic [7:0]  crc;
    logic [15:0] sw;
    logic        b, fb;
    crc = 8'd0;
    sw  = SYNC_WORD;
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(1'((i % 2) == 0));
    for (int i = SYNC_W - 1; i >= 0; i--) exp_q.push_back(sw[i]);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        b  = src[k][i];
        exp_q.push_back(b);
        fb  = crc[7] ^ b;
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ 8'h07;
      end
    end
    for (int i = CRC_BITS - 1; i >= 0; i--) exp_q.push_back(crc[i]);
    for (int i = 0; i < gap; i++) exp_q.push_back(1'b0);
  endtask

  // monitor: samples on the falling edge, a bit transfers at the following rising edge
  int   cyc = 0, bits_acc, hs_cnt, rdy_rise, done_cnt, ovalid_run, max_run, under_cyc, stab_err, last_acc;
  logic prev_rdy = 1'b0, held_v = 1'b0, held_d = 1'b0;
  logic [0:0] e_bit;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (bus.ovalid && bus.mod_ready) begin
        bits_acc++;
        last_acc = cyc;
        if (exp_q.size() == 0) check("extra bit", 1, 0);
        else begin
          e_bit = exp_q.pop_front();
          check("bit", int'(bus.odata), int'(e_bit));
        end
      end
      if (held_v && bus.ovalid && (bus.odata != held_d)) stab_err++;
      held_v = bus.ovalid && !bus.mod_ready;
      held_d = bus.odata;
      if (bus.s_valid && bus.s_ready) hs_cnt++;
      if (bus.s_ready && !prev_rdy) rdy_rise++;
      prev_rdy = bus.s_ready;
      if (bus.ovalid) ovalid_run++; else ovalid_run = 0;
      if (ovalid_run > max_run) max_run = ovalid_run;
      if (bus.busy && !bus.ovalid) under_cyc++;
      if (bus.done) begin
        done_cnt++;
        check("busy at done", int'(bus.busy), 0);
        check("ovalid at done", int'(bus.ovalid), 0);
        check("done after last bit", cyc - last_acc, 1);
      end
    end else begin
      prev_rdy   = 1'b0;
      held_v     = 1'b0;
      ovalid_run = 0;
    end
  end

  // driver for the byte source and modulator ready
  int mr_mode = 0, stall_at = -1, stall_left = 0;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       bus.mod_ready = 1'b1;
      1:       bus.mod_ready = ~bus.mod_ready;
      default: bus.mod_ready = 1'($urandom_range(0, 1));
    endcase
    if (hs_cnt < src.size()) begin
      if (hs_cnt == stall_at && stall_left > 0) begin
        bus.s_valid = 1'b0;
        stall_left--;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = src[hs_cnt];
      end
    end else begin
      bus.s_valid = 1'b0;
    end
  end

  task automatic clear_stats();
    bits_acc = 0; hs_cnt = 0; rdy_rise = 0; done_cnt = 0;
    max_run = 0; under_cyc = 0; stab_err = 0; last_acc = 0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.len   = 8'($urandom_range(0, 255));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    src.delete();
    exp_q.delete();
    for (int i = 0; i < v.len; i++) src.push_back(v.seed + 8'(i * 37));
    build_frame(v.len, GAP_LEN);
    clear_stats();
    mr_mode    = v.mr_mode;
    stall_at   = (v.stall > 0) ? 1 : -1;
    stall_left = v.stall;
    pulse_start(v.len);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(posedge clk); #2;
      if (v.mid_start != 0 && c == 20) begin
        bus.start = 1'b1;
        bus.len   = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (done_cnt == 0) check({tag, " timeout"}, 0, 1);
    repeat (6) @(posedge clk);
    #2;
    check({tag, " bits"}, bits_acc, v.exp_bits);
    check({tag, " leftover"}, exp_q.size(), 0);
    check({tag, " handshakes"}, hs_cnt, v.len);
    check({tag, " s_ready pulses"}, rdy_rise, v.len);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " busy idle"}, int'(bus.busy), 0);
    check({tag, " odata stable"}, stab_err, 0);
    if (v.mr_mode == 0 && v.stall == 0) check({tag, " ovalid run"}, max_run, v.exp_bits);
    if (v.stall > 0) check({tag, " underrun seen"}, int'(under_cyc > 0), 1);
  endtask

  vec_t vecs[7];
  logic [0:0] got2[$];
  int   rdy2, last2, done2;

  initial begin
    vecs[0] = '{1, 8'hA5, 0, 0,  0, 64 + CRC_BITS};
    vecs[1] = '{1, 8'hA5, 1, 0,  1, 64 + CRC_BITS};
    vecs[2] = '{3, 8'h3C, 0, 13, 0, 80 + CRC_BITS};
    vecs[3] = '{0, 8'h00, 0, 0,  0, 56 + CRC_BITS};
    vecs[4] = '{4, 8'hC3, 2, 0,  0, 88 + CRC_BITS};
    vecs[5] = '{1, 8'h01, 0, 0,  0, 64 + CRC_BITS};
    vecs[6] = '{2, 8'hFF, 1, 0,  0, 72 + CRC_BITS};

    rst = 1'b0;
    bus.start = 1'b0;  bus.len = 8'd0;
    bus2.start = 1'b0; bus2.len = 8'd0; bus2.s_valid = 1'b0; bus2.s_data = 8'd0; bus2.mod_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    check("reset ovalid", int'(bus.ovalid), 0);
    check("reset odata", int'(bus.odata), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset s_ready", int'(bus.s_ready), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // reset in the middle of the payload
    src.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) src.push_back(8'h90 + 8'(i));
    build_frame(4, GAP_LEN);
    clear_stats();
    mr_mode = 0; stall_at = -1; stall_left = 0;
    pulse_start(4);
    for (int c = 0; c < 500 && hs_cnt < 2; c++) begin
      @(posedge clk); #2;
    end
    check("reached payload", int'(hs_cnt >= 2), 1);
    #1 rst = 1'b0;
    #1;
    check("rst ovalid", int'(bus.ovalid), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst s_ready", int'(bus.s_ready), 0);
    check("rst done", int'(bus.done), 0);
    src.delete(); exp_q.delete();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("no done after reset", done_cnt, 0);
    check("idle after reset", int'(bus.busy), 0);
    run_vec('{1, 8'h5A, 0, 0, 0, 64 + CRC_BITS}, 7);

    // start held across the done cycle: ignored on done, accepted one cycle later
    src.delete(); exp_q.delete();
    build_frame(0, GAP_LEN);
    build_frame(0, GAP_LEN);
    clear_stats();
    pulse_start(0);
    for (int c = 0; c < 2000 && !bus.done; c++) begin
      @(posedge clk); #2;
    end
    check("done seen", int'(bus.done), 1);
    bus.start = 1'b1;
    bus.len   = 8'd0;
    @(posedge clk); #2;
    check("start on done ignored", int'(bus.busy), 0);
    @(posedge clk); #2;
    check("start after done taken", int'(bus.busy), 1);
    bus.start = 1'b0;
    for (int c = 0; c < 2000 && done_cnt < 2; c++) begin
      @(posedge clk); #2;
    end
    check("two frames done", done_cnt, 2);
    check("two frames bits", bits_acc, 2 * (56 + CRC_BITS));
    check("two frames leftover", exp_q.size(), 0);

    // GAP_LEN=0 instance, len=0
    src.delete(); exp_q.delete();
    build_frame(0, 0);
    exp2_q = exp_q;
    exp_q.delete();
    rdy2 = 0; last2 = 0; done2 = -1;
    @(posedge clk); #2;
    bus2.start = 1'b1;
    @(posedge clk); #2;
    bus2.start = 1'b0;
    for (int c = 0; c < 300 && done2 < 0; c++) begin
      @(negedge clk);
      if (bus2.ovalid && bus2.mod_ready) begin
        got2.push_back(bus2.odata);
        last2 = c;
      end
      if (bus2.s_ready) rdy2++;
      if (bus2.done) done2 = c;
    end
    check("g0 bits", got2.size(), 48 + CRC_BITS);
    for (int i = 0; i < got2.size() && i < exp2_q.size(); i++)
      check($sformatf("g0 bit %0d", i), int'(got2[i]), int'(exp2_q[i]));
    check("g0 s_ready", rdy2, 0);
    check("g0 done after last bit", done2 - last2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
